// File: rtl/cdma_wr_master.sv
// -----------------------------------------------------------------------------
// cdma_wr_master
//
// Destination-side write engine of the CDMA datapath. Pops 32-bit words from
// the CDMA data buffer and writes them to memory over AHB-Lite. It uses INCR4
// bursts when the address is 16-byte aligned, at least four words remain and
// at least four words are buffered. Otherwise it uses SINGLE transfers.
//
// State | meaning
// ------+----------------------------------------------------------------------
// IDLE  | waiting for start; bus idle
// WAIT  | choose the next transfer (INCR4 / SINGLE), or finish when rem is 0
// XFER  | address phases of the current transfer; data phases overlap
// LAST  | final data phase of the transfer still outstanding
// ERR   | second cycle of an ERROR response; remaining beats cancelled
// DONE  | one-cycle done pulse; err valid here
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   start              one-cycle pulse; ignored while busy
//   dst_addr           destination byte address (bits [1:0] dropped)
//   xfer_words         number of 32-bit words to write
//   busy, done, err    status; err qualifies done
//   buf_rd             pops the buffer head word
//   buf_rdata          buffer head word
//   buf_buf_word       buffered word count (registered in the buffer)
//   buf_empty          buffer empty flag (used only by an assertion)
//   haddr .. hwdata    AHB-Lite master outputs
//   hready, hresp      AHB-Lite slave response
// -----------------------------------------------------------------------------
module cdma_wr_master (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] dst_addr,
  input  logic [15:0] xfer_words,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        buf_rd,
  input  logic [31:0] buf_rdata,
  input  logic [5:0]  buf_buf_word,
  input  logic        buf_empty,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic        hresp
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_XFER = 3'd2;
  localparam logic [2:0] S_LAST = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  logic [2:0]  state_q,  state_d;
  logic [31:0] addr_q,   addr_d;
  logic [15:0] rem_q,    rem_d;
  logic [2:0]  beats_q,  beats_d;
  logic        dp_q,     dp_d;
  logic        err_q,    err_d;
  logic [2:0]  hburst_q, hburst_d;

  logic        err_hit;
  logic        first_beat;

  // First cycle of a two-cycle ERROR response on an outstanding data phase.
  assign err_hit = dp_q & hresp & ~hready &
                   ((state_q == S_XFER) || (state_q == S_LAST));

  // A SINGLE is always a lone NONSEQ; an INCR4 is NONSEQ only on its first beat.
  assign first_beat = (hburst_q == HBURST_SINGLE) || (beats_q == 3'd4);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    beats_d  = beats_q;
    dp_d     = dp_q;
    err_d    = err_q;
    hburst_d = hburst_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = dst_addr & 32'hFFFF_FFFC;
          rem_d   = xfer_words;
          err_d   = 1'b0;
          dp_d    = 1'b0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (rem_q == 16'd0) begin
          state_d = S_DONE;
        end else if ((rem_q >= 16'd4) && (addr_q[3:2] == 2'b00) &&
                     (buf_buf_word >= 6'd4)) begin
          hburst_d = HBURST_INCR4;
          beats_d  = 3'd4;
          state_d  = S_XFER;
        end else if (buf_buf_word != 6'd0) begin
          hburst_d = HBURST_SINGLE;
          beats_d  = 3'd1;
          state_d  = S_XFER;
        end
      end

      S_XFER: begin
        if (err_hit) begin
          // Drop the pending address phase and any beats still to come.
          beats_d = 3'd0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (hready) begin
          addr_d  = addr_q + 32'd4;
          rem_d   = rem_q - 16'd1;
          beats_d = beats_q - 3'd1;
          dp_d    = 1'b1;
          if (beats_q == 3'd1) begin
            state_d = S_LAST;
          end
        end
      end

      S_LAST: begin
        if (err_hit) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (hready) begin
          dp_d    = 1'b0;
          state_d = S_WAIT;
        end
      end

      S_ERR: begin
        // The second error cycle still completes the data phase and pops.
        if (hready) begin
          dp_d    = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'd0;
      rem_q    <= 16'd0;
      beats_q  <= 3'd0;
      dp_q     <= 1'b0;
      err_q    <= 1'b0;
      hburst_q <= HBURST_SINGLE;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      beats_q  <= beats_d;
      dp_q     <= dp_d;
      err_q    <= err_d;
      hburst_q <= hburst_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign err    = done & err_q;

  // The buffer pointer moves only when a data phase completes, so hwdata
  // holds through wait states without a local data register.
  assign buf_rd = dp_q & hready;
  assign hwdata = buf_rdata;

  assign haddr  = addr_q;
  assign htrans = (state_q == S_XFER) ?
                  (first_beat ? HTRANS_NONSEQ : HTRANS_SEQ) : HTRANS_IDLE;
  assign hwrite = busy;
  assign hsize  = 3'b010;
  assign hburst = hburst_q;

  a_no_pop_when_empty: assert property (
    @(posedge clk) disable iff (!rstn) buf_rd |-> !buf_empty
  );

endmodule

// File: tb/tb_cdma_wr_master.sv
module tb_cdma_wr_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [31:0] dst_addr;
  logic [15:0] xfer_words;
  logic        busy, done, err, buf_rd;
  logic [31:0] buf_rdata;
  logic [5:0]  buf_buf_word;
  logic        buf_empty;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;

  always #5 clk = ~clk;

  cdma_wr_master dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .dst_addr     (dst_addr),
    .xfer_words   (xfer_words),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .buf_rd       (buf_rd),
    .buf_rdata    (buf_rdata),
    .buf_buf_word (buf_buf_word),
    .buf_empty    (buf_empty),
    .haddr        (haddr),
    .htrans       (htrans),
    .hwrite       (hwrite),
    .hsize        (hsize),
    .hburst       (hburst),
    .hwdata       (hwdata),
    .hready       (hready),
    .hresp        (hresp)
  );

  // Buffer model: registered pointers, head word combinational.
  logic [31:0] bmem [0:63];
  logic [5:0]  wr_ptr;
  logic [5:0]  rd_ptr;

  assign buf_rdata    = bmem[rd_ptr];
  assign buf_buf_word = wr_ptr - rd_ptr;
  assign buf_empty    = (buf_buf_word == 6'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       rd_ptr <= 6'd0;
    else if (buf_rd) rd_ptr <= rd_ptr + 6'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor, sampled on the falling edge.
  logic [31:0] a_addr  [0:255];
  logic [1:0]  a_trans [0:255];
  logic [2:0]  a_burst [0:255];
  logic [31:0] p_data  [0:255];
  int          p_cyc   [0:255];
  int n_addr = 0, n_pop = 0, n_act = 0, n_done = 0, n_empty_rd = 0;
  int done_cyc = 0;
  logic done_err = 1'b0;

  always @(negedge clk) begin
    if (rstn) begin
      if (htrans != 2'b00) n_act = n_act + 1;
      if (htrans != 2'b00 && hready && n_addr < 256) begin
        a_addr[n_addr]  = haddr;
        a_trans[n_addr] = htrans;
        a_burst[n_addr] = hburst;
        n_addr = n_addr + 1;
      end
      if (buf_rd && n_pop < 256) begin
        p_data[n_pop] = hwdata;
        p_cyc[n_pop]  = cyc;
        n_pop = n_pop + 1;
        if (buf_empty) n_empty_rd = n_empty_rd + 1;
      end
      if (done) begin
        done_cyc = cyc;
        done_err = err;
        n_done = n_done + 1;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int st_cyc, d0, ab, pb, a0, e0;

  task automatic push(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      bmem[wr_ptr] = base + 32'(i);
      wr_ptr = wr_ptr + 6'd1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; start = 1'b0; hready = 1'b1; hresp = 1'b0;
    dst_addr = 32'd0; xfer_words = 16'd0; wr_ptr = 6'd0;
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns 1 unit after the next one.
  task automatic start_xfer(input logic [31:0] a, input logic [15:0] n);
    st_cyc = cyc; d0 = n_done; ab = n_addr; pb = n_pop; a0 = n_act; e0 = n_empty_rd;
    dst_addr = a; xfer_words = n; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int k = 0;
    while (n_done == d0 && k < max) begin
      @(negedge clk);
      k++;
    end
    chk_eq({tag, "_done_seen"}, 32'(n_done - d0), 32'd1);
  endtask

  logic [31:0] e2_addr  [0:5] = '{32'h1008, 32'h100C, 32'h1010, 32'h1014, 32'h1018, 32'h101C};
  logic [1:0]  e2_trans [0:5] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11};
  logic [2:0]  e2_burst [0:5] = '{3'b000, 3'b000, 3'b011, 3'b011, 3'b011, 3'b011};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; hready = 1'b1; hresp = 1'b0;
    dst_addr = 32'd0; xfer_words = 16'd0; wr_ptr = 6'd0;
    #3;
    chk_eq("rst_busy",   32'(busy),   32'd0);
    chk_eq("rst_done",   32'(done),   32'd0);
    chk_eq("rst_err",    32'(err),    32'd0);
    chk_eq("rst_buf_rd", 32'(buf_rd), 32'd0);
    chk_eq("rst_haddr",  haddr,       32'd0);
    chk_eq("rst_htrans", 32'(htrans), 32'd0);
    chk_eq("rst_hwrite", 32'(hwrite), 32'd0);
    chk_eq("rst_hsize",  32'(hsize),  32'd2);
    chk_eq("rst_hburst", 32'(hburst), 32'd0);

    // T1: aligned INCR4, plenty of data, no wait states.
    do_reset();
    push(24, 32'hA100_0000);
    start_xfer(32'h0000_1000, 16'd4);
    wait_done("t1", 60);
    chk_eq("t1_latency", 32'(done_cyc - st_cyc), 32'd8);
    chk_eq("t1_err", 32'(done_err), 32'd0);
    chk_eq("t1_naddr", 32'(n_addr - ab), 32'd4);
    chk_eq("t1_npop", 32'(n_pop - pb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk_eq($sformatf("t1_addr%0d", i), a_addr[ab+i], 32'h1000 + 32'(4*i));
      chk_eq($sformatf("t1_trans%0d", i), 32'(a_trans[ab+i]), (i == 0) ? 32'd2 : 32'd3);
      chk_eq($sformatf("t1_burst%0d", i), 32'(a_burst[ab+i]), 32'd3);
      chk_eq($sformatf("t1_pop%0d", i), p_data[pb+i], 32'hA100_0000 + 32'(i));
    end
    chk_eq("t1_pop_span", 32'(p_cyc[pb+3] - p_cyc[pb]), 32'd3);
    @(negedge clk);
    chk_eq("t1_busy_after", 32'(busy), 32'd0);

    // T2: misaligned start -> two SINGLEs then an INCR4.
    do_reset();
    push(6, 32'hB200_0000);
    start_xfer(32'h0000_100A, 16'd6);
    wait_done("t2", 80);
    chk_eq("t2_err", 32'(done_err), 32'd0);
    chk_eq("t2_naddr", 32'(n_addr - ab), 32'd6);
    chk_eq("t2_npop", 32'(n_pop - pb), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk_eq($sformatf("t2_addr%0d", i), a_addr[ab+i], e2_addr[i]);
      chk_eq($sformatf("t2_trans%0d", i), 32'(a_trans[ab+i]), 32'(e2_trans[i]));
      chk_eq($sformatf("t2_burst%0d", i), 32'(a_burst[ab+i]), 32'(e2_burst[i]));
      chk_eq($sformatf("t2_pop%0d", i), p_data[pb+i], 32'hB200_0000 + 32'(i));
    end

    // T3: empty buffer for 10 cycles, then 2 words arrive.
    do_reset();
    start_xfer(32'h0000_2000, 16'd2);
    repeat (10) @(posedge clk);
    #1;
    chk_eq("t3_idle_act", 32'(n_act - a0), 32'd0);
    chk_eq("t3_idle_pop", 32'(n_pop - pb), 32'd0);
    chk_eq("t3_busy", 32'(busy), 32'd1);
    push(2, 32'hC300_0000);
    wait_done("t3", 60);
    chk_eq("t3_err", 32'(done_err), 32'd0);
    chk_eq("t3_naddr", 32'(n_addr - ab), 32'd2);
    chk_eq("t3_npop", 32'(n_pop - pb), 32'd2);
    chk_eq("t3_empty_rd", 32'(n_empty_rd - e0), 32'd0);
    for (int i = 0; i < 2; i++) begin
      chk_eq($sformatf("t3_addr%0d", i), a_addr[ab+i], 32'h2000 + 32'(4*i));
      chk_eq($sformatf("t3_trans%0d", i), 32'(a_trans[ab+i]), 32'd2);
      chk_eq($sformatf("t3_burst%0d", i), 32'(a_burst[ab+i]), 32'd0);
      chk_eq($sformatf("t3_pop%0d", i), p_data[pb+i], 32'hC300_0000 + 32'(i));
    end

    // T4: INCR4 with 3 wait states during the second data phase.
    do_reset();
    push(4, 32'hD400_0000);
    start_xfer(32'h0000_3000, 16'd4);
    for (int i = 2; i <= 8; i++) begin
      @(posedge clk);
      #1 hready = !(i >= 4 && i <= 6);
      @(negedge clk);
      if (i >= 4 && i <= 6) begin
        chk_eq($sformatf("t4_haddr_c%0d", i), haddr, 32'h0000_3008);
        chk_eq($sformatf("t4_htrans_c%0d", i), 32'(htrans), 32'd3);
        chk_eq($sformatf("t4_hwdata_c%0d", i), hwdata, 32'hD400_0001);
        chk_eq($sformatf("t4_buf_rd_c%0d", i), 32'(buf_rd), 32'd0);
      end
    end
    wait_done("t4", 60);
    chk_eq("t4_latency", 32'(done_cyc - st_cyc), 32'd11);
    chk_eq("t4_err", 32'(done_err), 32'd0);
    chk_eq("t4_naddr", 32'(n_addr - ab), 32'd4);
    chk_eq("t4_npop", 32'(n_pop - pb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk_eq($sformatf("t4_addr%0d", i), a_addr[ab+i], 32'h3000 + 32'(4*i));
      chk_eq($sformatf("t4_pop%0d", i), p_data[pb+i], 32'hD400_0000 + 32'(i));
    end

    // T5: ERROR response on the second data phase of an INCR4.
    do_reset();
    push(4, 32'hE500_0000);
    start_xfer(32'h0000_4000, 16'd4);
    for (int i = 2; i <= 6; i++) begin
      @(posedge clk);
      #1;
      hresp  = (i == 4 || i == 5);
      hready = (i != 4);
      @(negedge clk);
      if (i == 5) begin
        chk_eq("t5_htrans_err2", 32'(htrans), 32'd0);
        chk_eq("t5_buf_rd_err2", 32'(buf_rd), 32'd1);
      end
    end
    hresp = 1'b0;
    wait_done("t5", 40);
    chk_eq("t5_latency", 32'(done_cyc - st_cyc), 32'd6);
    chk_eq("t5_err", 32'(done_err), 32'd1);
    chk_eq("t5_naddr", 32'(n_addr - ab), 32'd2);
    chk_eq("t5_npop", 32'(n_pop - pb), 32'd2);
    chk_eq("t5_pop0", p_data[pb], 32'hE500_0000);
    chk_eq("t5_pop1", p_data[pb+1], 32'hE500_0001);
    chk_eq("t5_left", 32'(buf_buf_word), 32'd2);
    @(negedge clk);
    chk_eq("t5_busy_after", 32'(busy), 32'd0);
    chk_eq("t5_err_after", 32'(err), 32'd0);

    // T6: zero-length transfer.
    do_reset();
    start_xfer(32'h0000_5000, 16'd0);
    wait_done("t6", 20);
    chk_eq("t6_latency", 32'(done_cyc - st_cyc), 32'd2);
    chk_eq("t6_err", 32'(done_err), 32'd0);
    chk_eq("t6_act", 32'(n_act - a0), 32'd0);
    chk_eq("t6_naddr", 32'(n_addr - ab), 32'd0);

    // T7: reset asserted mid-burst.
    do_reset();
    push(4, 32'hF600_0000);
    start_xfer(32'h0000_6000, 16'd4);
    repeat (2) @(posedge clk);
    #1;
    chk_eq("t7_pre_htrans", 32'(htrans), 32'd3);
    rstn = 1'b0;
    #1;
    chk_eq("t7_busy",   32'(busy),   32'd0);
    chk_eq("t7_done",   32'(done),   32'd0);
    chk_eq("t7_err",    32'(err),    32'd0);
    chk_eq("t7_buf_rd", 32'(buf_rd), 32'd0);
    chk_eq("t7_haddr",  haddr,       32'd0);
    chk_eq("t7_htrans", 32'(htrans), 32'd0);
    chk_eq("t7_hwrite", 32'(hwrite), 32'd0);
    chk_eq("t7_hburst", 32'(hburst), 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk_eq("t7_no_done", 32'(n_done - d0), 32'd0);
    chk_eq("t7_idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
